// File: rtl/filter_pkg.sv
// Shared window-filter definitions: default pixel geometry, window bit layout and
// the window-position FSM encoding. Used by window_gen and the downstream filter.
package filter_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_H = 3;
    localparam int WIN_W = 3;
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_ACTIVE = 2'd2
    } win_state_t;

    // Bit offset of pixel (h,w) in a flattened window; w=0 is the newest column.
    function automatic int win_off(input int h, input int w, input int height, input int pix_w);
        return ((w * height) + h) * pix_w;
    endfunction

endpackage

// File: rtl/window_pos.sv
// Column/row position tracker for window_gen: config registers, counters and FSM.
// Produces accept/emit/last strobes for the beat currently on up_val. Honours WINDOW_PAD_EN.
module window_pos
    import filter_pkg::*;
#(
    parameter int WIDTH_NB  = WIN_W,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] cfg_cols,
    input  logic [CNT_WIDTH-1:0] cfg_rows,
    input  logic                 cfg_set,
    input  logic                 up_val,
    output logic                 accept,
    output logic                 emit,
    output logic                 last,
    output logic                 clear,
    output logic [CNT_WIDTH-1:0] col_cnt,
    output win_state_t           state
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(WIDTH_NB - 1);

    logic [CNT_WIDTH-1:0] cols_q;
    logic [CNT_WIDTH-1:0] rows_q;
    logic [CNT_WIDTH-1:0] row_cnt;
    logic                 col_end;
    logic                 row_end;

    assign col_end = (col_cnt == cols_q - ONE);
    assign row_end = (row_cnt == rows_q - ONE);

    // cfg_set wins over a same-cycle up_val, which is simply dropped.
    assign clear  = cfg_set;
    assign accept = up_val && !cfg_set && (state != ST_IDLE);
    assign last   = accept && col_end && row_end;

`ifdef WINDOW_PAD_EN
    assign emit = accept;
`else
    assign emit = accept && (col_cnt >= FILL_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cols_q  <= '0;
            rows_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            state   <= ST_IDLE;
        end else if (cfg_set) begin
            cols_q  <= cfg_cols;
            rows_q  <= cfg_rows;
            col_cnt <= '0;
            row_cnt <= '0;
            state   <= (cfg_cols != '0 && cfg_rows != '0) ? ST_FILL : ST_IDLE;
        end else if (accept) begin
            if (col_end) begin
                col_cnt <= '0;
                if (row_end) begin
                    row_cnt <= '0;
                    state   <= ST_IDLE;
                end else begin
                    row_cnt <= row_cnt + ONE;
                    state   <= ST_FILL;
                end
            end else begin
                col_cnt <= col_cnt + ONE;
                state   <= (col_cnt + ONE >= FILL_LAST) ? ST_ACTIVE : ST_FILL;
            end
        end
    end

endmodule

// File: rtl/window_gen.sv
// Kernel window generator: shifts pixel columns into a HEIGHT_NB x WIDTH_NB window and
// emits it in parallel, never straddling a row. WINDOW_PAD_EN zero-pads row-start windows.
module window_gen
    import filter_pkg::*;
#(
    parameter int HEIGHT_NB = WIN_H,
    parameter int WIDTH_NB  = WIN_W,
    parameter int IMG_WIDTH = PIX_W,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CNT_WIDTH-1:0]                  cfg_cols,
    input  logic [CNT_WIDTH-1:0]                  cfg_rows,
    input  logic                                  cfg_set,
    input  logic [IMG_WIDTH*HEIGHT_NB-1:0]        up_data,
    input  logic                                  up_val,
    output logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] dn_data,
    output logic                                  dn_val,
    output logic                                  dn_last,
    output win_state_t                            dbg_state
);

    localparam int COL_W = IMG_WIDTH * HEIGHT_NB;
    localparam int WIN_B = COL_W * WIDTH_NB;

    logic                 accept;
    logic                 emit;
    logic                 last;
    logic                 clear;
    logic [CNT_WIDTH-1:0] col_cnt;
    logic [COL_W-1:0]     sr [WIDTH_NB-1];
    logic [WIN_B-1:0]     next_win;

    window_pos #(
        .WIDTH_NB (WIDTH_NB),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .cfg_cols(cfg_cols),
        .cfg_rows(cfg_rows),
        .cfg_set (cfg_set),
        .up_val  (up_val),
        .accept  (accept),
        .emit    (emit),
        .last    (last),
        .clear   (clear),
        .col_cnt (col_cnt),
        .state   (dbg_state)
    );

    // Window as it will look once the current beat has been shifted in.
    always_comb begin
        next_win = '0;
        for (int h = 0; h < HEIGHT_NB; h++) begin
            next_win[win_off(h, 0, HEIGHT_NB, IMG_WIDTH) +: IMG_WIDTH] = up_data[h*IMG_WIDTH +: IMG_WIDTH];
            for (int w = 1; w < WIDTH_NB; w++) begin
`ifdef WINDOW_PAD_EN
                if (w <= int'(col_cnt))
                    next_win[win_off(h, w, HEIGHT_NB, IMG_WIDTH) +: IMG_WIDTH] = sr[w-1][h*IMG_WIDTH +: IMG_WIDTH];
`else
                next_win[win_off(h, w, HEIGHT_NB, IMG_WIDTH) +: IMG_WIDTH] = sr[w-1][h*IMG_WIDTH +: IMG_WIDTH];
`endif
            end
        end
    end

    // Stale columns from the previous row stay in sr; the FILL rule keeps them out of dn_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH_NB - 1; i++) sr[i] <= '0;
            dn_data <= '0;
            dn_val  <= 1'b0;
            dn_last <= 1'b0;
        end else begin
            dn_val  <= emit;
            dn_last <= last && emit;
            if (clear) begin
                for (int i = 0; i < WIDTH_NB - 1; i++) sr[i] <= '0;
            end else if (accept) begin
                sr[0] <= up_data;
                for (int i = 1; i < WIDTH_NB - 1; i++) sr[i] <= sr[i-1];
            end
            if (emit) dn_data <= next_win;
        end
    end

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: expected windows are queued as beats are issued and
// a negedge monitor pops and compares every dn_val cycle.
module tb_window_gen;
    import filter_pkg::*;

    localparam int H  = 3;
    localparam int W  = 3;
    localparam int IW = 8;
    localparam int CW = 12;
    localparam int DW = H * W * IW;

    logic              clk;
    logic              rst;
    logic [CW-1:0]     cfg_cols;
    logic [CW-1:0]     cfg_rows;
    logic              cfg_set;
    logic [H*IW-1:0]   up_data;
    logic              up_val;
    logic [DW-1:0]     dn_data;
    logic              dn_val;
    logic              dn_last;
    win_state_t        dbg_state;

    logic [DW:0]       exp_q[$];
    int                total;
    int                bad;

    window_gen #(
        .HEIGHT_NB(H),
        .WIDTH_NB (W),
        .IMG_WIDTH(IW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_cols (cfg_cols),
        .cfg_rows (cfg_rows),
        .cfg_set  (cfg_set),
        .up_data  (up_data),
        .up_val   (up_val),
        .dn_data  (dn_data),
        .dn_val   (dn_val),
        .dn_last  (dn_last),
        .dbg_state(dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- helpers ----
    // Window with every row of column w0/w1/w2 equal to the given pixel value.
    function automatic logic [DW:0] mk_win(input logic [7:0] w0, input logic [7:0] w1,
                                           input logic [7:0] w2, input logic lst);
        return {lst, {3{w2}}, {3{w1}}, {3{w0}}};
    endfunction

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] p);
        up_val  = 1'b1;
        up_data = {3{p}};
        step(1);
        up_val  = 1'b0;
    endtask

    task automatic config_frame(input int cols, input int rows);
        cfg_cols = CW'(cols);
        cfg_rows = CW'(rows);
        cfg_set  = 1'b1;
        step(1);
        cfg_set  = 1'b0;
    endtask

    task automatic drain(input string name);
        step(4);
        check(name, (DW+1)'(exp_q.size()), '0);
    endtask

    // ---- scoreboard monitor ----
    always @(negedge clk) begin
        if (rst) begin
            check("last_qualified", {{DW{1'b0}}, dn_last && !dn_val}, '0);
            if (dn_val) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_window: got %h want none", {dn_last, dn_data});
                end else begin
                    check("window", {dn_last, dn_data}, exp_q.pop_front());
                end
            end
        end
    end

    // ---- stimulus ----
    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        cfg_cols = '0;
        cfg_rows = '0;
        cfg_set  = 1'b0;
        up_data  = '0;
        up_val   = 1'b0;
        #2;
        check("reset_dn_val",  {{DW{1'b0}}, dn_val}, '0);
        check("reset_dn_last", {{DW{1'b0}}, dn_last}, '0);
        check("reset_dn_data", {1'b0, dn_data}, '0);
        check("reset_state",   (DW+1)'(dbg_state), (DW+1)'(ST_IDLE));
        step(2);
        rst = 1'b1;
        step(1);

        // IDLE after reset: beats ignored
        beat(8'h11);
        beat(8'h12);
        drain("idle_no_output");

        // Basic frame 5x2
        config_frame(5, 2);
        exp_q.push_back(mk_win(2, 1, 0, 0));
        exp_q.push_back(mk_win(3, 2, 1, 0));
        exp_q.push_back(mk_win(4, 3, 2, 0));
        exp_q.push_back(mk_win(7, 6, 5, 0));
        exp_q.push_back(mk_win(8, 7, 6, 0));
        exp_q.push_back(mk_win(9, 8, 7, 1));
        for (int k = 0; k < 10; k++) beat(8'(k));
        drain("basic_all_windows");
        check("basic_end_state", (DW+1)'(dbg_state), (DW+1)'(ST_IDLE));
        beat(8'h33);
        drain("after_frame_idle");

        // Gapped input: one idle cycle between beats
        config_frame(5, 2);
        exp_q.push_back(mk_win(2, 1, 0, 0));
        exp_q.push_back(mk_win(3, 2, 1, 0));
        exp_q.push_back(mk_win(4, 3, 2, 0));
        exp_q.push_back(mk_win(7, 6, 5, 0));
        exp_q.push_back(mk_win(8, 7, 6, 0));
        exp_q.push_back(mk_win(9, 8, 7, 1));
        for (int k = 0; k < 10; k++) begin
            beat(8'(k));
            step(1);
            check("gap_dn_val_low", {{DW{1'b0}}, dn_val}, '0);
        end
        drain("gapped_all_windows");

        // cfg_set mid-frame with a colliding beat
        config_frame(5, 2);
        exp_q.push_back(mk_win(2, 1, 0, 0));
        for (int k = 0; k < 3; k++) beat(8'(k));
        cfg_set = 1'b1;
        up_val  = 1'b1;
        up_data = {3{8'h55}};
        step(1);
        cfg_set = 1'b0;
        up_val  = 1'b0;
        exp_q.push_back(mk_win(8'h0c, 8'h0b, 8'h0a, 0));
        beat(8'h0a);
        beat(8'h0b);
        beat(8'h0c);
        drain("cfg_set_restart");

        // Narrow rows: no windows, no dn_last
        config_frame(2, 2);
        for (int k = 0; k < 4; k++) beat(8'(k + 20));
        drain("narrow_no_windows");
        check("narrow_end_state", (DW+1)'(dbg_state), (DW+1)'(ST_IDLE));

        // Zero config stays IDLE
        config_frame(0, 3);
        check("zero_cfg_state", (DW+1)'(dbg_state), (DW+1)'(ST_IDLE));
        for (int k = 0; k < 4; k++) beat(8'(k + 40));
        drain("zero_cfg_no_output");

`ifdef WINDOW_PAD_EN
        config_frame(4, 1);
        exp_q.push_back(mk_win(1, 0, 0, 0));
        exp_q.push_back(mk_win(2, 1, 0, 0));
        exp_q.push_back(mk_win(3, 2, 1, 0));
        exp_q.push_back(mk_win(4, 3, 2, 1));
        for (int k = 1; k <= 4; k++) beat(8'(k));
        drain("pad_windows");
`endif

        // Async reset mid-stream while dn_val is high
        config_frame(5, 2);
        beat(8'h01);
        beat(8'h02);
        beat(8'h03);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_dn_val",  {{DW{1'b0}}, dn_val}, '0);
        check("async_rst_dn_last", {{DW{1'b0}}, dn_last}, '0);
        check("async_rst_dn_data", {1'b0, dn_data}, '0);
        check("async_rst_state",   (DW+1)'(dbg_state), (DW+1)'(ST_IDLE));
        step(1);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) beat(8'(k + 60));
        drain("post_reset_ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
Downstream partner of the line-delay block. It consumes the vertical pixel column stream of HEIGHT_NB pixels per beat, plus its valid. It shifts columns horizontally into a HEIGHT_NB x WIDTH_NB kernel window and emits the whole window in parallel to the filter. It tracks column/row position from runtime config so windows never straddle a row boundary, and it flags the last window of a frame.

Parameters:
HEIGHT_NB, 3, window rows (must match the line-delay block)
WIDTH_NB, 3, window columns, >=2
IMG_WIDTH, 8, bits per pixel
CNT_WIDTH, 12, width of column/row counters and config

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
cfg_cols  input  CNT_WIDTH  columns per image row
cfg_rows  input  CNT_WIDTH  column-rows per frame (rows arriving at up_*)
cfg_set  input  1  latch cfg_cols/cfg_rows, restart frame
up_data  input  IMG_WIDTH*HEIGHT_NB  pixel column; slice h = row h, h=0 newest row
up_val  input  1  up_data valid
dn_data  output  IMG_WIDTH*HEIGHT_NB*WIDTH_NB  window; pixel (h,w) at [((w*HEIGHT_NB)+h)*IMG_WIDTH +: IMG_WIDTH], w=0 newest column
dn_val  output  1  dn_data valid
dn_last  output  1  last window of frame, qualified by dn_val

Behaviour:
- No backpressure. A valid-only stream, one column per up_val beat; gaps are allowed.
- Reset (rst low, async): dn_data=0, dn_val=0, dn_last=0, shift register=0, counters=0, cfg regs=0, state IDLE.
- States:
  - IDLE: config zero or frame complete; up_val ignored. Leaves only on cfg_set.
  - FILL: col_cnt < WIDTH_NB-1 in the current row.
  - ACTIVE: col_cnt >= WIDTH_NB-1.
- cfg_set (highest priority, any state):
  - Latches config; col_cnt=row_cnt=0; clears the shift register; dn_val=0 next cycle.
  - up_val in the same cycle is dropped.
  - Next state is FILL if cfg_cols!=0 and cfg_rows!=0, else IDLE.
- On each accepted up_val:
  - Shift register moves w -> w+1; up_data enters at w=0.
  - col_cnt increments.
  - At col_cnt==cfg_cols-1: col_cnt wraps to 0, row_cnt increments, state returns to FILL.
  - At row_cnt==cfg_rows-1 with col_cnt==cfg_cols-1 (frame end): counters clear, state becomes IDLE.
- Output timing:
  - dn_val registered, 1 cycle after the accepted beat.
  - dn_val is asserted iff that beat's col_cnt (before increment) >= WIDTH_NB-1.
  - dn_data updates only with dn_val and holds otherwise.
- dn_last=1 with the window from the frame-end beat, and 0 otherwise.
- Row boundary: the shift register is not cleared at row wrap. Stale columns are masked solely by the FILL rule.
- Windows per frame: (cfg_cols-WIDTH_NB+1)*cfg_rows.
- cfg_cols < WIDTH_NB: no windows are produced. Counters still advance, and dn_last is lost (documented limitation).
- Counters compare using CNT_WIDTH-bit equality; there is no overflow beyond the cfg range.

Optional Feature:
Macro WINDOW_PAD_EN.
- Defined:
  - dn_val follows every accepted up_val, giving cfg_cols windows per row.
  - Window columns with w > col_cnt (before the current row start) read as zero.
  - dn_last is produced for any cfg_cols>=1.
- Undefined: behaviour as above, with no padding and no mask logic.

Decomposition:
- Shared package `filter_pkg` holds:
  - Pixel-width constants.
  - The window index function (h,w) -> bit offset, shared with the filter.
  - State encoding IDLE/FILL/ACTIVE.
- One natural sub-module, `window_pos`: the col/row counters, config registers, and FSM. It outputs accept, emit and last strobes.
- The shift register and output register stay in the top level.

Test Plan:
- Reset mid-stream: drive rst low during ACTIVE -> dn_val, dn_last and dn_data become 0 immediately (async). up_val ignored until cfg_set.
- Basic window: cfg_cols=5, cfg_rows=2, defaults, columns c0..c9 with c_k pixels = k -> 6 windows. First window follows c2 by 1 cycle with w0=2, w1=1, w2=0. No window for c5/c6. dn_last with the window from c9.
- Gapped input: same config, up_val toggling 1/0 -> identical window sequence. dn_val only in the cycle after each accepted beat.
- cfg_set mid-frame: after 3 columns, pulse cfg_set together with up_val=1 -> that beat is dropped. Next window appears only after 3 fresh columns.
- Boundary: cfg_cols=2 (<WIDTH_NB) -> zero windows, no dn_last. cfg_cols=0 -> stays IDLE, no outputs.
- WINDOW_PAD_EN, cfg_cols=4, cfg_rows=1 -> 4 windows. First window has w1=w2=0; second has w2=0. dn_last on the 4th.
